// File: rtl/spike_event_dispatcher.sv
// spike_event_dispatcher: turns each accepted spike into one event-FIFO entry per fan-out synapse.
// Latency: handshake edge to first fifo_enq is 4 cycles. Steady state is 3 cycles per synapse.
// Backpressure: spike_ready is high only in IDLE. PUSH holds its entry stable while fifo_full is high.
//
// Ports:
//   clk, asyn_reset_n               clock (rising edge) and asynchronous active-low reset
//   spike_valid/ready/id/tag        spike request handshake from the neuron update stage
//   ptr_rd/addr, ptr_base/count     fan-out table read; data returns 1 cycle after ptr_rd
//   syn_rd/addr, syn_weight/dst     synapse memory read; data returns 1 cycle after syn_rd
//   fifo_full, fifo_enq             event FIFO push side; fifo_enq = PUSH & !fifo_full
//   weight_out/dst_out/src_tag_out  registered entry fields, held outside PUSH
//   busy                            high in every state except IDLE
//
// Build option: define DISPATCH_ZERO_SKIP_EN to drop synapses whose weight magnitude is zero
// (+0 or -0) instead of enqueueing them. The address and remaining count still advance.
module spike_event_dispatcher #(
    parameter int WEIGHT_W  = 17,
    parameter int NEURON_AW = 8,
    parameter int SYN_AW    = 12,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 asyn_reset_n,
    input  logic                 spike_valid,
    output logic                 spike_ready,
    input  logic [NEURON_AW-1:0] spike_id,
    input  logic                 spike_tag,
    output logic                 ptr_rd,
    output logic [NEURON_AW-1:0] ptr_addr,
    input  logic [SYN_AW-1:0]    ptr_base,
    input  logic [CNT_W-1:0]     ptr_count,
    output logic                 syn_rd,
    output logic [SYN_AW-1:0]    syn_addr,
    input  logic [WEIGHT_W-1:0]  syn_weight,
    input  logic [NEURON_AW-1:0] syn_dst,
    input  logic                 fifo_full,
    output logic                 fifo_enq,
    output logic [WEIGHT_W-1:0]  weight_out,
    output logic [NEURON_AW-1:0] dst_out,
    output logic                 src_tag_out,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_FETCH,
        S_CAPTURE,
        S_PUSH
    } state_t;

    state_t               state;
    logic [NEURON_AW-1:0] id_q;
    logic                 tag_q;
    logic [SYN_AW-1:0]    addr_q;
    logic [CNT_W-1:0]     remain_q;
    logic                 last_syn;

    // Table and synapse addresses come straight from the captured registers.
    assign ptr_addr = id_q;
    assign syn_addr = addr_q;

    // Only output that is combinational: the FIFO must see the push in the same cycle it frees up.
    assign fifo_enq = (state == S_PUSH) && !fifo_full;

    // The synapse being finished is the final one of this fan-out.
    assign last_syn = (remain_q == CNT_W'(1));

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state       <= S_IDLE;
            id_q        <= '0;
            tag_q       <= 1'b0;
            addr_q      <= '0;
            remain_q    <= '0;
            spike_ready <= 1'b1;
            busy        <= 1'b0;
            ptr_rd      <= 1'b0;
            syn_rd      <= 1'b0;
            weight_out  <= '0;
            dst_out     <= '0;
            src_tag_out <= 1'b0;
        end else begin
            // Read strobes are single-cycle pulses raised on entry to LOOKUP / FETCH.
            ptr_rd <= 1'b0;
            syn_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (spike_valid) begin
                        id_q        <= spike_id;
                        tag_q       <= spike_tag;
                        ptr_rd      <= 1'b1;
                        spike_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    addr_q   <= ptr_base;
                    remain_q <= ptr_count;
                    if (ptr_count == '0) begin
                        spike_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        syn_rd <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
`ifdef DISPATCH_ZERO_SKIP_EN
                    if (syn_weight[WEIGHT_W-2:0] == '0) begin
                        // Zero-magnitude synapse: consume it without touching the output fields.
                        addr_q   <= addr_q + SYN_AW'(1);
                        remain_q <= remain_q - CNT_W'(1);
                        if (last_syn) begin
                            spike_ready <= 1'b1;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            syn_rd <= 1'b1;
                            state  <= S_FETCH;
                        end
                    end else begin
                        weight_out  <= syn_weight;
                        dst_out     <= syn_dst;
                        src_tag_out <= tag_q;
                        state       <= S_PUSH;
                    end
`else
                    weight_out  <= syn_weight;
                    dst_out     <= syn_dst;
                    src_tag_out <= tag_q;
                    state       <= S_PUSH;
`endif
                end
                S_PUSH: begin
                    if (!fifo_full) begin
                        // Address wraps naturally at the register width.
                        addr_q   <= addr_q + SYN_AW'(1);
                        remain_q <= remain_q - CNT_W'(1);
                        if (last_syn) begin
                            spike_ready <= 1'b1;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            syn_rd <= 1'b1;
                            state  <= S_FETCH;
                        end
                    end
                end
                default: begin
                    spike_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_event_dispatcher.sv
// tb_spike_event_dispatcher: table-driven and randomized checks of spike_event_dispatcher.
// Fan-out table and synapse memory are modelled as 1-cycle-latency arrays that return noise
// when not read; expected entries come from walking the arrays with plain modular arithmetic.
module tb_spike_event_dispatcher;

`ifdef DISPATCH_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        asyn_reset_n;
    logic        spike_valid;
    logic        spike_ready;
    logic [7:0]  spike_id;
    logic        spike_tag;
    logic        ptr_rd;
    logic [7:0]  ptr_addr;
    logic [11:0] ptr_base;
    logic [7:0]  ptr_count;
    logic        syn_rd;
    logic [11:0] syn_addr;
    logic [16:0] syn_weight;
    logic [7:0]  syn_dst;
    logic        fifo_full;
    logic        fifo_enq;
    logic [16:0] weight_out;
    logic [7:0]  dst_out;
    logic        src_tag_out;
    logic        busy;

    spike_event_dispatcher dut (
        .clk         (clk),
        .asyn_reset_n(asyn_reset_n),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_id    (spike_id),
        .spike_tag   (spike_tag),
        .ptr_rd      (ptr_rd),
        .ptr_addr    (ptr_addr),
        .ptr_base    (ptr_base),
        .ptr_count   (ptr_count),
        .syn_rd      (syn_rd),
        .syn_addr    (syn_addr),
        .syn_weight  (syn_weight),
        .syn_dst     (syn_dst),
        .fifo_full   (fifo_full),
        .fifo_enq    (fifo_enq),
        .weight_out  (weight_out),
        .dst_out     (dst_out),
        .src_tag_out (src_tag_out),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memories
    logic [11:0] tb_base [256];
    logic [7:0]  tb_cnt  [256];
    logic [16:0] mem_w   [4096];
    logic [7:0]  mem_d   [4096];

    always @(posedge clk) begin
        if (ptr_rd) begin
            ptr_base  <= tb_base[ptr_addr];
            ptr_count <= tb_cnt[ptr_addr];
        end else begin
            ptr_base  <= 12'($urandom);
            ptr_count <= 8'($urandom);
        end
        if (syn_rd) begin
            syn_weight <= mem_w[syn_addr];
            syn_dst    <= mem_d[syn_addr];
        end else begin
            syn_weight <= 17'($urandom);
            syn_dst    <= 8'($urandom);
        end
    end

    // Cycle counter and monitor
    int          cyc = 0;
    int          acc;
    bit          acc_seen;
    int          busy_cyc;
    int          inv_bad;
    int          stall_bad;
    int          stall_len;
    int          full_mode;
    logic [16:0] hold_w;
    logic [7:0]  hold_d;
    logic [25:0] got_e [$];
    int          got_c [$];
    logic [11:0] got_a [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (asyn_reset_n) begin
            if (spike_valid && spike_ready) begin
                acc      = cyc + 1;
                acc_seen = 1'b1;
            end
            if (fifo_enq) begin
                got_e.push_back({weight_out, dst_out, src_tag_out});
                got_c.push_back(cyc);
            end
            if (syn_rd) got_a.push_back(syn_addr);
            if (acc_seen && busy) busy_cyc++;
            if (stall_len > 0 && acc_seen && cyc >= acc + 4 && cyc < acc + 4 + stall_len)
                if (fifo_enq || weight_out != hold_w || dst_out != hold_d) stall_bad++;
            if (spike_ready == busy) inv_bad++;
        end
    end

    // fifo_full driver: scripted stall window or random toggling
    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (full_mode == 1) fifo_full = ($urandom_range(0, 2) == 0);
            else fifo_full = (stall_len > 0 && acc_seen && cyc >= acc + 4 && cyc < acc + 4 + stall_len);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [50:0] out_vec();
        return {spike_ready, ptr_rd, ptr_addr, syn_rd, syn_addr, fifo_enq,
                weight_out, dst_out, src_tag_out, busy};
    endfunction

    task automatic run_spike(input logic [7:0] id, input logic tag, input int stall,
                             output int lat, output int bcyc, output int gap,
                             output logic [16:0] w0, output logic [7:0] d0, output logic [11:0] sa_last);
        logic [25:0] ex_e [$];
        logic [11:0] ex_a [$];
        logic [11:0] a;
        int n;
        for (int k = 0; k < int'(tb_cnt[id]); k++) begin
            a = 12'((int'(tb_base[id]) + k) % 4096);
            ex_a.push_back(a);
            if (!(SKIP && mem_w[a][15:0] == 16'h0)) ex_e.push_back({mem_w[a], mem_d[a], tag});
        end
        hold_w = (ex_e.size() > 0) ? ex_e[0][25:9] : 17'h0;
        hold_d = (ex_e.size() > 0) ? ex_e[0][8:1] : 8'h0;
        got_e.delete(); got_c.delete(); got_a.delete();
        busy_cyc = 0; inv_bad = 0; stall_bad = 0; stall_len = stall; acc_seen = 1'b0;
        @(posedge clk);
        #1;
        spike_id = id; spike_tag = tag; spike_valid = 1'b1;
        n = 0;
        while (!acc_seen && n < 50) begin step(); n++; end
        chk("accept_in_time", acc_seen, 1);
        @(posedge clk);
        #1;
        spike_valid = 1'b0;
        n = 0;
        while (busy && n < 5000) begin step(); n++; end
        chk("done_in_time", (n < 5000), 1);
        repeat (4) step();
        chk("n_enq", got_e.size(), ex_e.size());
        for (int i = 0; i < got_e.size() && i < ex_e.size(); i++) chk($sformatf("entry%0d", i), got_e[i], ex_e[i]);
        chk("n_syn_rd", got_a.size(), ex_a.size());
        for (int i = 0; i < got_a.size() && i < ex_a.size(); i++) chk($sformatf("syn_addr%0d", i), got_a[i], ex_a[i]);
        chk("ready_vs_busy", inv_bad, 0);
        chk("stall_hold", stall_bad, 0);
        lat     = (got_c.size() > 0) ? got_c[0] - acc : -1;
        gap     = (got_c.size() > 1) ? got_c[1] - got_c[0] : 0;
        bcyc    = busy_cyc;
        w0      = (got_e.size() > 0) ? got_e[0][25:9] : 17'h0;
        d0      = (got_e.size() > 0) ? got_e[0][8:1] : 8'h0;
        sa_last = (got_a.size() > 0) ? got_a[got_a.size()-1] : 12'h0;
        stall_len = 0;
    endtask

    typedef struct {
        logic [7:0]  id;
        logic        tag;
        int          stall;
        int          exp_n;
        int          exp_lat;
        int          exp_busy;
        int          exp_gap;
        logic [16:0] exp_w0;
        logic [7:0]  exp_d0;
        logic [11:0] exp_sa_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat, bcyc, gap, n;
        logic [16:0] w0;
        logic [7:0]  d0;
        logic [11:0] sa;
        logic [50:0] rst_vec;
        logic [11:0] za;

        asyn_reset_n = 1'b0; spike_valid = 1'b0; spike_id = 8'h0; spike_tag = 1'b0;
        full_mode = 0; stall_len = 0; acc_seen = 1'b0; acc = 0;
        rst_vec = {1'b1, 50'h0};

        // Synapse memory: nonzero magnitudes everywhere unless placed explicitly.
        for (int a = 0; a < 4096; a++) begin
            mem_w[a] = {1'($urandom), 16'($urandom_range(1, 65535))};
            mem_d[a] = 8'($urandom);
        end
        for (int i = 0; i < 256; i++) begin
            tb_base[i] = 12'($urandom);
            tb_cnt[i]  = 8'($urandom_range(0, 12));
        end
        mem_w[12'h010] = 17'h00800; mem_d[12'h010] = 8'd5;
        mem_w[12'h011] = 17'h00100; mem_d[12'h011] = 8'd6;
        mem_w[12'hFFF] = 17'h1ABCD; mem_d[12'hFFF] = 8'd7;
        mem_w[12'h000] = 17'h00123; mem_d[12'h000] = 8'd8;
        mem_w[12'h100] = 17'h00000; mem_d[12'h100] = 8'd9;
        mem_w[12'h101] = 17'h10000; mem_d[12'h101] = 8'd10;
        mem_w[12'h102] = 17'h00200; mem_d[12'h102] = 8'd11;
        mem_w[12'h200] = 17'h0BEEF; mem_d[12'h200] = 8'h42;
        tb_base[3] = 12'h010; tb_cnt[3] = 8'd2;
        tb_base[4] = 12'h020; tb_cnt[4] = 8'd0;
        tb_base[5] = 12'h010; tb_cnt[5] = 8'd2;
        tb_base[6] = 12'hFFF; tb_cnt[6] = 8'd2;
        tb_base[7] = 12'h100; tb_cnt[7] = 8'd3;
        tb_base[8] = 12'h200; tb_cnt[8] = 8'd255;
        tb_base[9] = 12'h300; tb_cnt[9] = 8'd4;

        //          id  tag stall n    lat busy gap  w0         d0     sa_last
        vecs[0] = '{8'd3, 1'b1, 0, 2,   4,  8,   3, 17'h00800, 8'd5,  12'h011};
        vecs[1] = '{8'd4, 1'b0, 0, 0,  -1,  2,   0, 17'h00000, 8'd0,  12'h000};
        vecs[2] = '{8'd5, 1'b0, 5, 2,   9,  13,  3, 17'h00800, 8'd5,  12'h011};
        vecs[3] = '{8'd6, 1'b1, 0, 2,   4,  8,   3, 17'h1ABCD, 8'd7,  12'h000};
`ifdef DISPATCH_ZERO_SKIP_EN
        vecs[4] = '{8'd7, 1'b0, 0, 1,   8,  9,   0, 17'h00200, 8'd11, 12'h102};
`else
        vecs[4] = '{8'd7, 1'b0, 0, 3,   4,  11,  3, 17'h00000, 8'd9,  12'h102};
`endif
        vecs[5] = '{8'd8, 1'b1, 0, 255, 4,  767, 3, 17'h0BEEF, 8'h42, 12'h2FE};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_vec(), rst_vec);
        @(negedge clk);
        asyn_reset_n = 1'b1;
        step();
        chk("idle_outputs", out_vec(), rst_vec);

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            run_spike(vecs[v].id, vecs[v].tag, vecs[v].stall, lat, bcyc, gap, w0, d0, sa);
            chk($sformatf("v%0d_n", v), got_e.size(), vecs[v].exp_n);
            chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_busy", v), bcyc, vecs[v].exp_busy);
            chk($sformatf("v%0d_gap", v), gap, vecs[v].exp_gap);
            chk($sformatf("v%0d_w0", v), w0, vecs[v].exp_w0);
            chk($sformatf("v%0d_d0", v), d0, vecs[v].exp_d0);
            chk($sformatf("v%0d_sa_last", v), sa, vecs[v].exp_sa_last);
            chk($sformatf("v%0d_ready_back", v), spike_ready, 1);
        end

        // Reset during the second FETCH of a 4-synapse walk
        got_e.delete(); got_c.delete(); got_a.delete(); acc_seen = 1'b0;
        @(posedge clk);
        #1;
        spike_id = 8'd9; spike_tag = 1'b1; spike_valid = 1'b1;
        n = 0;
        while (!acc_seen && n < 50) begin step(); n++; end
        @(posedge clk);
        #1;
        spike_valid = 1'b0;
        n = 0;
        while (got_a.size() < 2 && n < 100) begin step(); n++; end
        chk("rst_reach_fetch2", got_a.size(), 2);
        chk("rst_enq_before", got_e.size(), 1);
        asyn_reset_n = 1'b0;
        #1;
        chk("rst_mid_walk_outputs", out_vec(), rst_vec);
        repeat (2) @(posedge clk);
        @(negedge clk);
        asyn_reset_n = 1'b1;
        got_e.delete(); got_a.delete();
        repeat (20) step();
        chk("post_rst_enq", got_e.size(), 0);
        chk("post_rst_syn_rd", got_a.size(), 0);
        chk("post_rst_ready", spike_ready, 1);

        // Randomized: random fifo_full, some zero-magnitude weights of either sign
        for (int j = 0; j < 300; j++) begin
            za = 12'($urandom);
            mem_w[za] = {1'($urandom), 16'h0};
        end
        full_mode = 1;
        for (int r = 0; r < 40; r++)
            run_spike(8'($urandom_range(16, 255)), 1'($urandom), 0, lat, bcyc, gap, w0, d0, sa);
        full_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
